// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared constants and types for the SPI frame receiver
package spi_rx_pkg;
   localparam int DATA_W      = 24;
   localparam int CRC_W       = 8;
   localparam int FRAME_W     = DATA_W + CRC_W;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 6;

   localparam logic [CRC_W-1:0] CRC_POLY = 8'h1D;
   localparam logic [CRC_W-1:0] CRC_INIT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CLOSE = 2'd2
   } rx_state_e;
endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-flop synchroniser with rise/fall detect for one SPI pin
module spi_in_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] chain_q;
   logic              prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= {STAGES{RST_VAL}};
         prev_q  <= RST_VAL;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], async_i};
         prev_q  <= chain_q[STAGES-1];
      end
   end

   assign sync_o = chain_q[STAGES-1];
   assign rise_o = sync_o & ~prev_q;
   assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI mode-0 slave receiving 24-bit payload + CRC8 per CS_n window
module spi_frame_rx
   import spi_rx_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic [DATA_W-1:0] rx_data,
   output logic [CRC_W-1:0]  rx_crc,
   output logic              rx_crc_ok,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_len_err,
   output logic              rx_overrun
);
   logic sclk_rise, unused_sclk_sync, unused_sclk_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic mosi_sync, unused_mosi_rise, unused_mosi_fall;

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .async_i(spi_sclk),
      .sync_o(unused_sclk_sync), .rise_o(sclk_rise), .fall_o(unused_sclk_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .async_i(spi_cs_n),
      .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .async_i(spi_mosi),
      .sync_o(mosi_sync), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
   );

   rx_state_e          state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [CRC_W-1:0]   crc_q, crc_d;
   logic [FRAME_W-1:0] shift_q;
   logic [1:0]         warm_q;
   logic               armed_q;
   logic [DATA_W-1:0]  rx_data_q;
   logic [CRC_W-1:0]   rx_crc_q;
   logic               rx_crc_ok_q, rx_valid_q, rx_len_err_q, rx_overrun_q;

   logic crc_fb, frame_fall, slot_free, len_ok;

   always_comb begin
      crc_fb     = crc_q[CRC_W-1] ^ mosi_sync;
      crc_d      = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
      // A CS_n already low when reset released must not open a frame:
      // only falls seen after a genuine high level are accepted.
      frame_fall = cs_fall & armed_q;
      slot_free  = ~rx_valid_q | rx_ready;
      len_ok     = (bit_cnt_q == CNT_W'(FRAME_W));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         crc_q        <= CRC_INIT;
         shift_q      <= '0;
         warm_q       <= '0;
         armed_q      <= 1'b0;
         rx_data_q    <= '0;
         rx_crc_q     <= '0;
         rx_crc_ok_q  <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_len_err_q <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         rx_len_err_q <= 1'b0;
         rx_overrun_q <= 1'b0;

         if (warm_q != 2'(SYNC_STAGES)) begin
            warm_q <= warm_q + 2'd1;
         end else if (cs_sync) begin
            armed_q <= 1'b1;
         end

         if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (frame_fall) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= '0;
                  crc_q     <= CRC_INIT;
                  shift_q   <= '0;
               end
            end

            SHIFT: begin
               if (cs_rise) begin
                  state_q <= CLOSE;
               end else if (sclk_rise) begin
                  shift_q <= {shift_q[FRAME_W-2:0], mosi_sync};
                  if (bit_cnt_q != {CNT_W{1'b1}}) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                  if (bit_cnt_q < CNT_W'(DATA_W)) begin
                     crc_q <= crc_d;
                  end
               end
            end

            CLOSE: begin
               if (!len_ok) begin
                  rx_len_err_q <= 1'b1;
               end else if (slot_free) begin
                  rx_data_q   <= shift_q[FRAME_W-1:CRC_W];
                  rx_crc_q    <= shift_q[CRC_W-1:0];
                  rx_crc_ok_q <= (crc_q == shift_q[CRC_W-1:0]);
                  rx_valid_q  <= 1'b1;
               end else begin
                  rx_overrun_q <= 1'b1;
               end

               if (frame_fall) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= '0;
                  crc_q     <= CRC_INIT;
                  shift_q   <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_crc     = rx_crc_q;
   assign rx_crc_ok  = rx_crc_ok_q;
   assign rx_valid   = rx_valid_q;
   assign rx_len_err = rx_len_err_q;
   assign rx_overrun = rx_overrun_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed and table-driven bench for spi_frame_rx
module tb_spi_frame_rx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_sclk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        rx_ready = 1'b1;
   logic [23:0] rx_data;
   logic [7:0]  rx_crc;
   logic        rx_crc_ok, rx_valid, rx_len_err, rx_overrun;

   spi_frame_rx dut (
      .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .rx_data(rx_data), .rx_crc(rx_crc), .rx_crc_ok(rx_crc_ok), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_len_err(rx_len_err), .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] crc8(input logic [23:0] d);
      logic [7:0] c;
      logic       fb;
      c = 8'hFF;
      for (int i = 23; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
      end
      return c;
   endfunction

   logic [31:0] cap_q[$];
   logic        cap_ok_q[$];
   int          len_err_cnt = 0, overrun_cnt = 0, valid_rise_cnt = 0, unstable_cnt = 0;
   logic        prev_hold = 1'b0, prev_valid = 1'b0, prev_ok = 1'b0;
   logic [31:0] prev_out = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_hold  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (rx_valid && rx_ready) begin
            cap_q.push_back({rx_data, rx_crc});
            cap_ok_q.push_back(rx_crc_ok);
         end
         if (rx_len_err) len_err_cnt++;
         if (rx_overrun) overrun_cnt++;
         if (rx_valid && !prev_valid) valid_rise_cnt++;
         if (prev_hold && (!rx_valid || {rx_data, rx_crc} !== prev_out || rx_crc_ok !== prev_ok))
            unstable_cnt++;
         prev_hold  = rx_valid && !rx_ready;
         prev_valid = rx_valid;
         prev_out   = {rx_data, rx_crc};
         prev_ok    = rx_crc_ok;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      wait_clk(3);
   endtask

   task automatic send_bit(input logic b, input int half);
      spi_mosi = b;
      wait_clk(half);
      spi_sclk = 1'b1;
      wait_clk(half);
      spi_sclk = 1'b0;
   endtask

   task automatic cs_high();
      wait_clk(3);
      spi_cs_n = 1'b1;
      wait_clk(6);
   endtask

   task automatic send_frame(input logic [63:0] bits, input int n, input int half);
      cs_low();
      for (int i = n - 1; i >= 0; i--) send_bit(bits[i], half);
      cs_high();
   endtask

   task automatic expect_frame(input string name, input logic [23:0] d, input logic [7:0] c,
                               input logic ok);
      int t;
      logic [31:0] got;
      logic        got_ok;
      t = 0;
      while (cap_q.size() == 0 && t < 100) begin
         wait_clk(1);
         t++;
      end
      if (cap_q.size() == 0) begin
         check({name, "_present"}, 32'd0, 32'd1);
      end else begin
         got    = cap_q.pop_front();
         got_ok = cap_ok_q.pop_front();
         check({name, "_data"}, {8'd0, got[31:8]}, {8'd0, d});
         check({name, "_crc"}, {24'd0, got[7:0]}, {24'd0, c});
         check({name, "_ok"}, {31'd0, got_ok}, {31'd0, ok});
      end
   endtask

   typedef struct {
      logic [23:0] data;
      logic [7:0]  crc;
      logic        exp_ok;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #990000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int le0, vr0, ov0;
      logic [23:0] d;
      logic [23:0] a_d, b_d, c_d;

      vecs[0] = '{24'h000000, 8'h0E, 1'b1};
      vecs[1] = '{24'h000000, 8'h0F, 1'b0};
      vecs[2] = '{24'hFFFFFF, crc8(24'hFFFFFF), 1'b1};
      vecs[3] = '{24'h123456, crc8(24'h123456), 1'b1};
      vecs[4] = '{24'h800001, crc8(24'h800001) ^ 8'h80, 1'b0};
      vecs[5] = '{24'hA5A5A5, crc8(24'hA5A5A5), 1'b1};

      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_data", {8'd0, rx_data}, 32'd0);
      check("rst_crc", {24'd0, rx_crc}, 32'd0);
      check("rst_ok", {31'd0, rx_crc_ok}, 32'd0);
      check("rst_len_err", {31'd0, rx_len_err}, 32'd0);
      check("rst_overrun", {31'd0, rx_overrun}, 32'd0);

      for (int v = 0; v < 6; v++) begin
         send_frame({32'd0, vecs[v].data, vecs[v].crc}, 32, 2);
         expect_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].crc, vecs[v].exp_ok);
      end

      for (int r = 0; r < 100; r++) begin
         d = 24'($urandom);
         send_frame({32'd0, d, crc8(d)}, 32, int'($urandom_range(2, 8)));
         expect_frame($sformatf("rand%0d", r), d, crc8(d), 1'b1);
      end

      le0 = len_err_cnt;
      vr0 = valid_rise_cnt;
      send_frame({33'd0, 24'h0F0F0F, crc8(24'h0F0F0F), 7'd0} >> 8, 31, 2);
      send_frame({31'd0, 24'h0F0F0F, crc8(24'h0F0F0F), 1'b1}, 33, 2);
      wait_clk(10);
      check("len_err_pulses", len_err_cnt - le0, 32'd2);
      check("len_no_valid", valid_rise_cnt - vr0, 32'd0);
      check("len_no_capture", cap_q.size(), 32'd0);

      a_d = 24'h111111;
      b_d = 24'h222222;
      c_d = 24'h333333;
      ov0 = overrun_cnt;
      rx_ready = 1'b0;
      send_frame({32'd0, a_d, crc8(a_d)}, 32, 2);
      send_frame({32'd0, b_d, crc8(b_d)}, 32, 2);
      wait_clk(5);
      check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
      check("ovr_data_held", {8'd0, rx_data}, {8'd0, a_d});
      check("ovr_crc_held", {24'd0, rx_crc}, {24'd0, crc8(a_d)});
      check("ovr_pulses", overrun_cnt - ov0, 32'd1);
      check("ovr_stable", unstable_cnt, 32'd0);
      rx_ready = 1'b1;
      wait_clk(1);
      expect_frame("ovr_first", a_d, crc8(a_d), 1'b1);
      send_frame({32'd0, c_d, crc8(c_d)}, 32, 3);
      expect_frame("ovr_third", c_d, crc8(c_d), 1'b1);
      check("ovr_dropped", cap_q.size(), 32'd0);

      le0 = len_err_cnt;
      vr0 = valid_rise_cnt;
      cs_low();
      for (int i = 0; i < 12; i++) send_bit(i[0], 2);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) send_bit(i[1], 2);
      cs_high();
      wait_clk(10);
      check("rst_mid_no_valid", valid_rise_cnt - vr0, 32'd0);
      check("rst_mid_no_len_err", len_err_cnt - le0, 32'd0);
      check("rst_mid_no_capture", cap_q.size(), 32'd0);
      send_frame({32'd0, 24'hC0FFEE, crc8(24'hC0FFEE)}, 32, 2);
      expect_frame("after_rst", 24'hC0FFEE, crc8(24'hC0FFEE), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
